// File: rtl/div_32_pkg.sv
// rtl/div_32_pkg.sv - shared constants, types and helpers for the 32-bit divider
package div_32_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [WIDTH:0]   rem_t;

    // Two's complement negation with 32-bit wrap.
    function automatic word_t neg_word(input word_t v);
        return ~v + word_t'(1);
    endfunction

    // Unsigned magnitude; 0x80000000 maps to itself, which is the correct magnitude.
    function automatic word_t abs_word(input word_t v);
        return v[WIDTH-1] ? neg_word(v) : v;
    endfunction

endpackage

// File: rtl/div_32_if.sv
// rtl/div_32_if.sv - request/response bundle between the pipeline and the divider
interface div_32_if;
    import div_32_pkg::*;

    logic  ctrl_DIV;
    word_t data_operandA;
    word_t data_operandB;
    word_t data_result;
    logic  data_exception;
    logic  data_resultRDY;
    logic  busy;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step
    import div_32_pkg::*;
(
    input  rem_t  r_in,
    input  word_t q_in,
    input  word_t divisor,
    output rem_t  r_out,
    output word_t q_out
);

    logic [2*WIDTH:0] rq_sh;
    rem_t             trial;

    // Shift {R,Q} left, trial-subtract the divisor, keep the difference when it did not go negative.
    always_comb begin
        rq_sh = {r_in, q_in} << 1;
        trial = rq_sh[2*WIDTH:WIDTH] - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            r_out = trial;
            q_out = {rq_sh[WIDTH-1:1], 1'b1};
        end else begin
            r_out = rq_sh[2*WIDTH:WIDTH];
            q_out = rq_sh[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_32.sv
// rtl/div_32.sv - multicycle signed 32-bit restoring divider with ready pulse
module div_32
    import div_32_pkg::*;
(
    input  logic     clock,
    input  logic     resetn,
    div_32_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            b_mag_q, b_mag_d;
    logic             sign_q, sign_d;
    logic             divzero_q, divzero_d;
    rem_t             r_q, r_d;
    word_t            q_q, q_d;
    word_t            result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    rem_t             step_r;
    word_t            step_q;

    div_step u_step (
        .r_in    (r_q),
        .q_in    (q_q),
        .divisor (b_mag_q),
        .r_out   (step_r),
        .q_out   (step_q)
    );

    // Next-state logic: a start strobe always wins and restarts, otherwise walk RUN -> FIX -> DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_mag_d   = b_mag_q;
        sign_d    = sign_q;
        divzero_d = divzero_q;
        r_d       = r_q;
        q_d       = q_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;

        if (bus.ctrl_DIV) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            b_mag_d   = abs_word(bus.data_operandB);
            sign_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            divzero_d = (bus.data_operandB == '0);
            r_d       = '0;
            q_d       = abs_word(bus.data_operandA);
        end else begin
            case (state_q)
                ST_RUN: begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (divzero_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = sign_q ? neg_word(q_q) : q_q;
                        exc_d    = 1'b0;
                    end
                    rdy_d   = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
    end

    // State and datapath registers; reset clears everything and drops any in-flight operation.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            b_mag_q   <= '0;
            sign_q    <= 1'b0;
            divzero_q <= 1'b0;
            r_q       <= '0;
            q_q       <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_mag_q   <= b_mag_d;
            sign_q    <= sign_d;
            divzero_q <= divzero_d;
            r_q       <= r_d;
            q_q       <= q_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_div_32.sv
// tb/tb_div_32.sv - scoreboard bench for div_32 with directed vectors
module tb_div_32;

    typedef struct {
        logic [31:0] result;
        logic        exc;
        int          start_cyc;
    } exp_t;

    logic clock;
    logic resetn;
    int   cyc;
    int   n_vec;
    int   n_miss;
    exp_t sb[$];

    div_32_if bus ();

    div_32 dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (bus.data_resultRDY) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rdy: got rdy=1 result=%h, required no pulse", bus.data_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (bus.data_result !== e.result) begin
                    n_miss++;
                    $display("FAIL result: got %h, required %h", bus.data_result, e.result);
                end
                n_vec++;
                if (bus.data_exception !== e.exc) begin
                    n_miss++;
                    $display("FAIL exception: got %b, required %b", bus.data_exception, e.exc);
                end
                n_vec++;
                if (cyc - e.start_cyc + 1 != 34) begin
                    n_miss++;
                    $display("FAIL latency: got %0d edges, required 34", cyc - e.start_cyc + 1);
                end
                n_vec++;
                if (bus.busy !== 1'b0) begin
                    n_miss++;
                    $display("FAIL busy_at_rdy: got %b, required 0", bus.busy);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV      = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        int i;
        busy_cycles = 0;
        for (i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) busy_cycles++;
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
        exp_t e;
        int   bc;
        e.result    = er;
        e.exc       = ee;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        strobe(a, b);
        wait_done(bc);
    endtask

    initial begin
        exp_t e;
        int   bc;
        cyc    = 0;
        n_vec  = 0;
        n_miss = 0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exc",    {31'b0, bus.data_exception}, 32'h0);
        check("reset_rdy",    {31'b0, bus.data_resultRDY}, 32'h0);
        check("reset_busy",   {31'b0, bus.busy}, 32'h0);
        #1 resetn = 1'b1;
        @(negedge clock);
        #1;

        // 100 / 7 with busy-length measurement
        e.result = 32'h0000000E; e.exc = 1'b0; e.start_cyc = cyc + 1;
        sb.push_back(e);
        strobe(32'd100, 32'd7);
        wait_done(bc);
        check("busy_cycles", bc, 32'd33);

        run(-32'sd100, 32'd7,      32'hFFFFFFF2, 1'b0);
        run(32'd100,   -32'sd7,    32'hFFFFFFF2, 1'b0);
        run(-32'sd100, -32'sd7,    32'h0000000E, 1'b0);
        run(32'd5,     32'd0,      32'h00000000, 1'b1);
        run(32'd7,     32'd100,    32'h00000000, 1'b0);
        run(32'hFFFFFFFF, 32'd2,   32'h00000000, 1'b0);
        run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run(32'h7FFFFFFF, 32'd1,   32'h7FFFFFFF, 1'b0);

        // Abort: 1000/3 is restarted by 81/9; only one ready pulse expected.
        strobe(32'd1000, 32'd3);
        repeat (8) @(negedge clock);
        #1;
        check("hold_result", bus.data_result, 32'h7FFFFFFF);
        check("hold_busy",   {31'b0, bus.busy}, 32'h1);
        run(32'd81, 32'd9, 32'h00000009, 1'b0);
        repeat (3) @(negedge clock);
        #1;

        // Reset mid-operation.
        strobe(32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_result", bus.data_result, 32'h0);
        check("midrst_exc",    {31'b0, bus.data_exception}, 32'h0);
        check("midrst_busy",   {31'b0, bus.busy}, 32'h0);
        check("midrst_rdy",    {31'b0, bus.data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        #1 resetn = 1'b1;
        repeat (40) @(negedge clock);
        #1;
        run(32'd50, 32'd5, 32'h0000000A, 1'b0);
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
